mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 32, address width of the data memory port.
REQ-002 Parameter: DW, 32, data width of the data memory port.
REQ-003 Parameter: LOCK_MAX, 16, maximum consecutive locked grants to requester 1 (used only when MEM_ARB_LOCK_EN is defined).
REQ-004 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous and active-high.
REQ-006 Port: req0, req1  input  1 each  access request from the core (0) and the loader/debug port (1); held high until the matching gnt.
REQ-007 Port: we0, we1  input  1 each  1 = write, 0 = read; stable while req is high.
REQ-008 Port: addr0, addr1  input  AW each  word address; stable while req is high.
REQ-009 Port: wdata0, wdata1  input  DW each  write data; stable while req is high.
REQ-010 Port: lock1  input  1  requester 1 bus-lock request (ignored without MEM_ARB_LOCK_EN).
REQ-011 Port: gnt0, gnt1  output  1 each  one-cycle pulse: request accepted and driven to memory this cycle.
REQ-012 Port: done0, done1  output  1 each  one-cycle pulse: access complete; for reads, rdata is valid.
REQ-013 Port: rdata  output  DW  registered read data; shared by both requesters and qualified by done0/done1.
REQ-014 Port: mem_addr, mem_wdata, mem_wen  output  AW/DW/1  registered drive to the combinational-read data memory.
REQ-015 Port: mem_rdata  input  DW  combinational read data from the data memory.

Function
REQ-016 FSM states: IDLE, ACCESS, RESP; exactly one of gnt0/gnt1 is high in ACCESS, and both are low in other states.
REQ-017 IDLE: with any req high, the winner's we/addr/wdata are latched into the mem_* registers and the FSM moves to ACCESS; otherwise it stays in IDLE with mem_wen=0.
REQ-018 ACCESS: gnt of the winner = 1, mem_wen = latched we, and rdata captures mem_rdata at the end of the cycle for reads; next state is RESP.
REQ-019 RESP: done of the winner = 1 and mem_wen = 0; if any req (excluding the one just served) is pending, arbitrate and go directly to ACCESS, otherwise go to IDLE.
REQ-020 Latency: a req sampled in IDLE at edge k gives gnt in cycle k+1 and done in cycle k+2; peak throughput is one access per 2 cycles.
REQ-021 Arbitration is two-way round-robin: on simultaneous requests, the requester not granted last wins; the last-grant register updates on every entry to ACCESS.
REQ-022 A requester whose req drops before its gnt is not served; there is no error flag.
REQ-023 mem_wen is asserted for exactly one cycle per write access and is never asserted for a read.
REQ-024 rdata holds its value until the next read completes; a write leaves rdata unchanged.

Reset
REQ-025 When rst is high, the FSM goes asynchronously to IDLE; gnt0/1, done0/1 and mem_wen go to 0; mem_addr, mem_wdata and rdata go to 0; the last-grant register goes to 1, so the core wins the first tie; the lock counter goes to 0.
REQ-026 Reset asserted during ACCESS aborts the access with mem_wen low immediately, and no done is issued for it.

Configuration
REQ-027 With MEM_ARB_LOCK_EN defined: if requester 1 is granted while lock1=1, arbitration in RESP grants requester 1 again while req1 and lock1 stay high, overriding round-robin, for up to LOCK_MAX consecutive grants; after that, requester 0 wins the next tie if req0 is pending.
REQ-028 Without MEM_ARB_LOCK_EN: lock1 is unused, no lock counter exists, and arbitration is pure round-robin.

Structure
REQ-029 Package mem_arb_pkg holds the state enum (IDLE, ACCESS, RESP), the requester-ID typedef, and default AW/DW constants.
REQ-030 One sub-module, rr_picker, holds the combinational two-way round-robin winner selection from req0, req1 and the last-grant value.

Verification
REQ-031 Reset scenario: release rst with req0=1, we0=0, addr0=0x10, and mem holding 0xDEADBEEF -> gnt0 in cycle 1, done0 in cycle 2, rdata=0xDEADBEEF.
REQ-032 Write scenario: req1=1, we1=1, addr1=0x04, wdata1=0x12345678 -> mem_wen high for exactly 1 cycle with mem_addr=0x04, then done1; a subsequent read of 0x04 returns 0x12345678.
REQ-033 Contention scenario: req0 and req1 held high continuously -> grants alternate 0,1,0,1 with one gnt every 2 cycles.
REQ-034 Reset-abort scenario: assert rst during the ACCESS of a write -> mem_wen drops in the same cycle, no done is issued, and the FSM is in IDLE after reset release.
REQ-035 Lock scenario (MEM_ARB_LOCK_EN, LOCK_MAX=4): req0, req1 and lock1 held high after a grant to 1 -> 4 consecutive gnt1 pulses, then gnt0.
REQ-036 Dropped-request scenario: req1 pulsed for 1 cycle while requester 0 is in ACCESS -> gnt1 never asserted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester data-memory arbiter.
// Imported by rr_picker and mem_arbiter.
package mem_arb_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_CORE   = 1'b0;
  localparam req_id_t REQ_LOADER = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational two-way round-robin winner selection.
// On a tie the requester that did not receive the last grant wins.
module rr_picker
  import mem_arb_pkg::*;
(
  input  logic    req0,
  input  logic    req1,
  input  req_id_t last,
  output logic    any,
  output req_id_t win
);

  always_comb begin
    any = req0 | req1;
    if (req0 && req1)
      win = (last == REQ_CORE) ? REQ_LOADER : REQ_CORE;
    else if (req1)
      win = REQ_LOADER;
    else
      win = REQ_CORE;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a combinational-read data memory (IDLE/ACCESS/RESP).
// Optional requester-1 bus lock is built only when MEM_ARB_LOCK_EN is defined.
//
// state  | meaning
// IDLE   | no access in flight, mem_wen low
// ACCESS | winner granted, mem_* driven, read data captured at end of cycle
// RESP   | done to winner, re-arbitrate straight into ACCESS if another req waits
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wen,
  input  logic [DW-1:0] mem_rdata
);

  state_t  state, nxt_state;
  req_id_t last;
  req_id_t sel;
  logic    start;
  logic    pick_req0, pick_req1, pick_any;
  req_id_t pick_win;
  logic    lock_hold;

  // The requester just served is masked out of RESP arbitration.
  assign pick_req0 = req0 && !((state == RESP) && (last == REQ_CORE));
  assign pick_req1 = req1 && !((state == RESP) && (last == REQ_LOADER));

  rr_picker u_picker (
    .req0 (pick_req0),
    .req1 (pick_req1),
    .last (last),
    .any  (pick_any),
    .win  (pick_win)
  );

`ifdef MEM_ARB_LOCK_EN
  localparam int LW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  // Down-counter of remaining locked re-grants; zero ends the lock run.
  logic [LW-1:0] lock_left;

  assign lock_hold = (state == RESP) && (last == REQ_LOADER) && req1 && lock1 &&
                     (lock_left != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lock_left <= '0;
    else if (start) begin
      if ((sel == REQ_LOADER) && lock1)
        lock_left <= lock_hold ? (lock_left - LW'(1)) : LW'(LOCK_MAX - 1);
      else
        lock_left <= '0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = lock1;
  assign lock_hold   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    start     = 1'b0;
    sel       = pick_win;
    case (state)
      IDLE: begin
        if (pick_any) begin
          nxt_state = ACCESS;
          start     = 1'b1;
        end
      end
      ACCESS: nxt_state = RESP;
      RESP: begin
        if (lock_hold) begin
          nxt_state = ACCESS;
          start     = 1'b1;
          sel       = REQ_LOADER;
        end else if (pick_any) begin
          nxt_state = ACCESS;
          start     = 1'b1;
        end else begin
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    gnt0  = (state == ACCESS) && (last == REQ_CORE);
    gnt1  = (state == ACCESS) && (last == REQ_LOADER);
    done0 = (state == RESP)   && (last == REQ_CORE);
    done1 = (state == RESP)   && (last == REQ_LOADER);
  end

  // last doubles as the in-flight requester ID; it resets to the loader so the core wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last      <= REQ_LOADER;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wen   <= 1'b0;
      rdata     <= '0;
    end else begin
      mem_wen <= 1'b0;
      if ((state == ACCESS) && !mem_wen)
        rdata <= mem_rdata;
      if (start) begin
        last <= sel;
        if (sel == REQ_LOADER) begin
          mem_addr  <= addr1;
          mem_wdata <= wdata1;
          mem_wen   <= we1;
        end else begin
          mem_addr  <= addr0;
          mem_wdata <= wdata0;
          mem_wen   <= we0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single accesses plus
// hand-written reset, contention, reset-abort, dropped-request and lock sequences.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, done0, done1, mem_wen;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wen(mem_wen), .mem_rdata(mem_rdata)
  );

  // Combinational-read memory model, preloaded with 0xDEADBEEF at 0x10 while in reset.
  logic [DW-1:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (rst)
      mem[8'h10] <= 32'hDEADBEEF;
    else if (mem_wen)
      mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          id;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  task automatic drive(input vec_t v);
    if (v.id) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
  endtask

  // Called at a negedge with the FSM in IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    int   n;
    logic g;
    string t;
    t = $sformatf("vec%0d", idx);
    n = 0;
    drive(v);
    do begin
      @(negedge clk);
      n++;
      g = v.id ? gnt1 : gnt0;
    end while (!g && n < 8);
    chk({t, " gnt"}, g, 1'b1);
    chk({t, " latency"}, n, 1);
    chk({t, " other_gnt"}, v.id ? gnt0 : gnt1, 1'b0);
    chk({t, " mem_wen"}, mem_wen, v.we);
    chk({t, " mem_addr"}, mem_addr, v.addr);
    if (v.we) chk({t, " mem_wdata"}, mem_wdata, v.wdata);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk({t, " done"}, v.id ? done1 : done0, 1'b1);
    chk({t, " wen_resp"}, mem_wen, 1'b0);
    chk({t, " rdata"}, rdata, v.exp_rdata);
    @(negedge clk);
    chk({t, " idle_done"}, done0 | done1, 1'b0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 32'h04, 32'h12345678, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b0, 32'h04, 32'h0,        32'h12345678};
    vecs[2] = '{1'b0, 1'b1, 32'h20, 32'hA5A50001, 32'h12345678};
    vecs[3] = '{1'b1, 1'b0, 32'h20, 32'h0,        32'hA5A50001};
    vecs[4] = '{1'b1, 1'b1, 32'h21, 32'h0000FFFF, 32'hA5A50001};
    vecs[5] = '{1'b0, 1'b0, 32'h21, 32'h0,        32'h0000FFFF};
    vecs[6] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};

    // Reset state, then read of 0x10 released straight out of reset.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    @(negedge clk);
    @(negedge clk);
    chk("rst gnt", {gnt0, gnt1}, 2'b00);
    chk("rst done", {done0, done1}, 2'b00);
    chk("rst mem_wen", mem_wen, 1'b0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst rdata", rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("r0 gnt0", gnt0, 1'b1);
    chk("r0 mem_addr", mem_addr, 32'h10);
    chk("r0 mem_wen", mem_wen, 1'b0);
    req0 = 1'b0;
    @(negedge clk);
    chk("r0 done0", done0, 1'b1);
    chk("r0 rdata", rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("r0 idle", done0 | gnt0, 1'b0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Contention: last grant was requester 1, so core leads; expect 0,1,0,1 every 2 cycles.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h04;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("cont%0d gnt0", i), gnt0, (i % 4) == 0);
      chk($sformatf("cont%0d gnt1", i), gnt1, (i % 4) == 2);
      if ((i % 4) == 1) chk($sformatf("cont%0d rdata", i), rdata, 32'h12345678);
      if ((i % 4) == 3) chk($sformatf("cont%0d rdata", i), rdata, 32'hA5A50001);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("cont idle", dut.state == IDLE, 1'b1);

    // Reset abort during the ACCESS of a write.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'hBAD0BAD0;
    @(negedge clk);
    chk("abort gnt0", gnt0, 1'b1);
    chk("abort wen_pre", mem_wen, 1'b1);
    rst = 1'b1;
    req0 = 1'b0;
    #1;
    chk("abort wen_drop", mem_wen, 1'b0);
    chk("abort gnt_drop", gnt0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("abort%0d done", i), done0 | done1, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("abort idle", dut.state == IDLE, 1'b1);
    chk("abort done_after", done0 | done1, 1'b0);
    chk("abort mem_addr", mem_addr, 32'h0);
    chk("abort rdata", rdata, 32'h0);

    // Dropped request: req1 high only across the ACCESS cycle of requester 0.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    @(negedge clk);
    chk("drop gnt0", gnt0, 1'b1);
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h04;
    @(negedge clk);
    chk("drop done0", done0, 1'b1);
    req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("drop%0d gnt1", i), gnt1, 1'b0);
    end

`ifdef MEM_ARB_LOCK_EN
    // Lock: last grant was core, so requester 1 wins, then holds the bus for 4 grants.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h04; lock1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("lock%0d gnt1", i), gnt1, (i < 8) && ((i % 2) == 0));
      chk($sformatf("lock%0d gnt0", i), gnt0, i == 8);
    end
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    @(negedge clk);
    chk("lock idle", dut.state == IDLE, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
